flex_updown_counter: RTL

Parametrised successor to the team's flexible rollover counter. Adds up/down direction, wrap or saturate mode, synchronous load and a one-cycle terminal pulse, all with registered outputs. Used by the miner control path for nonce iteration, SHA round sequencing and timeout down-counting, where one counter type must serve every counting role.

---
 rtl/flex_counter_pkg.sv | 18 +
 rtl/flex_counter_next.sv | 54 +++++
 rtl/flex_updown_counter.sv | 111 +++++++++++
 3 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the flexible up/down counter family.
// The optional wrap tally is enabled with the FLEX_WRAP_COUNT_EN macro.
package flex_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_t;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

  localparam int DEF_NUM_CNT_BITS  = 8;
  localparam int DEF_WRAP_CNT_BITS = 16;

endpackage : flex_counter_pkg

// File: rtl/flex_counter_next.sv
// Combinational step logic: next count, next flag, terminal-reached condition
// and wrap event for one enabled count step.
module flex_counter_next
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
  input  logic [NUM_CNT_BITS-1:0] count_i,
  input  cnt_dir_t                dir_i,
  input  cnt_mode_t               mode_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] term_o,
  output logic [NUM_CNT_BITS-1:0] next_count_o,
  output logic                    next_flag_o,
  output logic                    tc_o,
  output logic                    wrap_event_o
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  always_comb begin
    term_o       = (dir_i == DIR_UP) ? rollover_val_i : CNT_ONE;
    next_count_o = count_i;
    wrap_event_o = 1'b0;

    if (dir_i == DIR_UP) begin
      if ((rollover_val_i == '0) && (mode_i == MODE_WRAP)) begin
        // Zero top means the full modulo range; the 0 -> 1 step is the wrap.
        next_count_o = count_i + CNT_ONE;
        wrap_event_o = (count_i == '0);
      end else if (count_i < rollover_val_i) begin
        next_count_o = count_i + CNT_ONE;
      end else if (mode_i == MODE_WRAP) begin
        next_count_o = CNT_ONE;
        wrap_event_o = 1'b1;
      end else begin
        next_count_o = rollover_val_i;
      end
    end else begin
      if (count_i > CNT_ONE) begin
        next_count_o = count_i - CNT_ONE;
      end else if (mode_i == MODE_WRAP) begin
        next_count_o = rollover_val_i;
        wrap_event_o = 1'b1;
      end else begin
        next_count_o = CNT_ONE;
      end
    end

    next_flag_o = (next_count_o == term_o);
    tc_o        = next_flag_o && (count_i != term_o);
  end

endmodule : flex_counter_next

// File: rtl/flex_updown_counter.sv
// Up/down wrap-or-saturate counter with load, clear and registered terminal
// flag/pulse. Define FLEX_WRAP_COUNT_EN to add the saturating wrap_count tally.
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
  parameter int WRAP_CNT_BITS = DEF_WRAP_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    count_enable,
  input  logic                    dir,
  input  logic                    mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    tc_pulse
`ifdef FLEX_WRAP_COUNT_EN
  ,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
`endif
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    tc_q, tc_d;

  logic [NUM_CNT_BITS-1:0] term;
  logic [NUM_CNT_BITS-1:0] step_count;
  logic                    step_flag;
  logic                    step_tc;
  logic                    step_wrap;

  flex_counter_next #(
    .NUM_CNT_BITS(NUM_CNT_BITS)
  ) u_next (
    .count_i       (count_q),
    .dir_i         (cnt_dir_t'(dir)),
    .mode_i        (cnt_mode_t'(mode)),
    .rollover_val_i(rollover_val),
    .term_o        (term),
    .next_count_o  (step_count),
    .next_flag_o   (step_flag),
    .tc_o          (step_tc),
    .wrap_event_o  (step_wrap)
  );

  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      flag_d  = (load_val == term);
    end else if (count_enable) begin
      count_d = step_count;
      flag_d  = step_flag;
      tc_d    = step_tc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      tc_q    <= tc_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign tc_pulse      = tc_q;

`ifdef FLEX_WRAP_COUNT_EN
  logic [WRAP_CNT_BITS-1:0] wrap_q, wrap_d;

  // Load never counts as a wrap; only an enabled step can raise the tally.
  always_comb begin
    wrap_d = wrap_q;
    if (clear) begin
      wrap_d = '0;
    end else if (!load && count_enable && step_wrap && (wrap_q != '1)) begin
      wrap_d = wrap_q + WRAP_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_count = wrap_q;
`else
  if (WRAP_CNT_BITS < 1) begin : g_bad_wrap_width
  end
`endif

endmodule : flex_updown_counter
